// File: rtl/fifo_flags.sv
// fifo_flags: 2^W x B synchronous FIFO with show-ahead read data, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Latency: a pushed word is visible on r_data after the push edge. Backpressure: no handshake;
// a push to a full FIFO is dropped unless a pop happens in the same cycle. A pop from an empty FIFO is ignored.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   rd, wr, w_data        - pop request, push request, push data
//   clr_err               - clears the sticky overflow and underflow flags
//   r_data                - head word (valid when empty=0)
//   full, empty           - count == 2^W, count == 0
//   almost_full/_empty    - count >= AF_LVL, count <= AE_LVL
//   count                 - words stored, 0..2^W
//   overflow, underflow   - sticky error flags
module fifo_flags #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = (1 << W) - 2,
  parameter int AE_LVL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         clr_err,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int DEPTH = 1 << W;
  localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);
  localparam logic [W:0] AF_C    = (W+1)'(AF_LVL);
  localparam logic [W:0] AE_C    = (W+1)'(AE_LVL);

  logic [B-1:0] mem_q [DEPTH];

  logic [W-1:0] wptr_q, wptr_d;
  logic [W-1:0] rptr_q, rptr_d;
  logic [W:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         af_q, af_d;
  logic         ae_q, ae_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         push_ok, pop_ok;

  always_comb begin
    // A pop frees the slot that a simultaneous push into a full FIFO reuses.
    push_ok = wr & (~full_q | rd);
    pop_ok  = rd & ~empty_q;

    wptr_d  = push_ok ? wptr_q + W'(1) : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + W'(1) : rptr_q;
    count_d = count_q + {{W{1'b0}}, push_ok} - {{W{1'b0}}, pop_ok};

    // Flags follow the next count so they move on the same edge as count.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    // New error events take priority over clr_err.
    ovf_d = (wr & ~rd & full_q) | (ovf_q & ~clr_err);
    unf_d = (rd & empty_q)      | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; a push coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_q[wptr_q] <= w_data;
    end
  end

  assign r_data       = mem_q[rptr_q];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed test of fifo_flags with B=8, W=2, AF_LVL=3, AE_LVL=1.
// Latency: inputs are applied 1 time unit after a rising edge and outputs checked 1 unit after the next.
// Backpressure: none; the bench drives rd/wr directly and checks acceptance through count and error flags.
module tb_fifo_flags;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd, wr, clr_err;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  fifo_flags #(.B(8), .W(2), .AF_LVL(3), .AE_LVL(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .rd           (rd),
    .wr           (wr),
    .w_data       (w_data),
    .clr_err      (clr_err),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic e, input logic ae,
                           input logic f, input logic af, input logic ov, input logic un);
    check({tag, ".count"}, 16'(count), 16'(cnt));
    check({tag, ".empty"}, 16'(empty), 16'(e));
    check({tag, ".almost_empty"}, 16'(almost_empty), 16'(ae));
    check({tag, ".full"}, 16'(full), 16'(f));
    check({tag, ".almost_full"}, 16'(almost_full), 16'(af));
    check({tag, ".overflow"}, 16'(overflow), 16'(ov));
    check({tag, ".underflow"}, 16'(underflow), 16'(un));
  endtask

  logic [7:0] fill_dat [4];
  logic [7:0] q [$];
  logic       wr_p [10];
  logic       rd_p [10];

  initial begin
    fill_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_p = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    rd_p = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 1};

    reset = 1'b1; rd = 1'b0; wr = 1'b0; clr_err = 1'b0; w_data = 8'h00;
    tick();
    tick();
    chk_state("reset", 0, 1, 1, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_state("idle", 0, 1, 1, 0, 0, 0, 0);

    // Fill to full, then one rejected push.
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; w_data = fill_dat[i];
      tick();
      chk_state($sformatf("fill%0d", i), i + 1, 0, (i + 1) <= 1, (i + 1) == 4, (i + 1) >= 3, 0, 0);
      check($sformatf("fill%0d.r_data", i), 16'(r_data), 16'h11);
    end
    w_data = 8'h55;
    tick();
    chk_state("ovf", 4, 0, 0, 1, 1, 1, 0);
    check("ovf.r_data", 16'(r_data), 16'h11);
    wr = 1'b0;

    // Drain, then one rejected pop.
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1;
      tick();
      chk_state($sformatf("drain%0d", i), 3 - i, i == 3, i >= 2, 0, i == 0, 1, 0);
      if (i < 3) check($sformatf("drain%0d.r_data", i), 16'(r_data), 16'(fill_dat[i + 1]));
    end
    tick();
    chk_state("unf", 0, 1, 1, 0, 0, 1, 1);
    rd = 1'b0;

    // Clear both errors.
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk_state("clr", 0, 1, 1, 0, 0, 0, 0);

    // Simultaneous rd&wr while full.
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; w_data = 8'(i + 1);
      tick();
    end
    chk_state("refill", 4, 0, 0, 1, 1, 0, 0);
    rd = 1'b1; wr = 1'b1; w_data = 8'hAA;
    tick();
    chk_state("full_rw", 4, 0, 0, 1, 1, 0, 0);
    check("full_rw.r_data", 16'(r_data), 16'h02);
    wr = 1'b0;
    tick();
    check("pop_a.r_data", 16'(r_data), 16'h03);
    tick();
    check("pop_b.r_data", 16'(r_data), 16'h04);
    tick();
    check("pop_c.r_data", 16'(r_data), 16'hAA);
    tick();
    chk_state("pop_d", 0, 1, 1, 0, 0, 0, 0);

    // Simultaneous rd&wr while empty.
    wr = 1'b1; w_data = 8'hBB;
    tick();
    chk_state("empty_rw", 1, 0, 1, 0, 0, 0, 1);
    check("empty_rw.r_data", 16'(r_data), 16'hBB);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("empty_rw.clr", 16'(underflow), 16'h0);

    // Interleaved traffic against a queue model; pointers wrap past 3.
    q.push_back(8'hBB);
    for (int i = 0; i < 10; i++) begin
      logic push, pop;
      push = wr_p[i] && (q.size() < 4 || rd_p[i]);
      pop  = rd_p[i] && (q.size() > 0);
      wr = wr_p[i]; rd = rd_p[i]; w_data = 8'hC0 + 8'(i);
      tick();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(8'hC0 + 8'(i));
      check($sformatf("wrap%0d.count", i), 16'(count), 16'(q.size()));
      if (q.size() > 0) check($sformatf("wrap%0d.r_data", i), 16'(r_data), 16'(q[0]));
    end
    wr = 1'b0; rd = 1'b0;

    // Bring to full, force overflow, then exercise clr_err.
    while (q.size() < 4) begin
      wr = 1'b1; w_data = 8'hE0 + 8'(q.size());
      tick();
      q.push_back(8'hE0 + 8'(q.size()));
    end
    tick();
    check("err.ovf_set", 16'(overflow), 16'h1);
    check("err.full", 16'(full), 16'h1);
    wr = 1'b0; clr_err = 1'b1;
    tick();
    check("err.clr_alone", 16'(overflow), 16'h0);
    wr = 1'b1;
    tick();
    check("err.set_wins", 16'(overflow), 16'h1);
    wr = 1'b0; clr_err = 1'b0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk_state("pre_rst", 3, 0, 0, 0, 1, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_state("mid_rst", 0, 1, 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
